jtag_bscan_ic: RTL and testbench

Parametrised JTAG-ready IC wrapper: an IEEE 1149.1 TAP controller, a configurable-width instruction register, a bypass register, a 32-bit IDCODE register and a boundary-scan register sized to the core's pin count. It sits between the chip pins and an arbitrary core and replaces the fixed 2-bit-IR, 4-in/2-out wrapper. The next generation adds IDCODE, TDO enable, a parametrised IR and parametrised boundary-scan lengths, and an optional INTEST.

---
 rtl/jtag_pkg.sv | 52 +++++
 rtl/jtag_tap_fsm.sv | 57 +++++
 rtl/jtag_bscan_ic.sv | 189 ++++++++++++++++++
 tb/tb_jtag_bscan_ic.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP state codes, opcodes and register-select type for the boundary-scan wrapper.
package jtag_pkg;

   localparam logic [3:0] ST_TLR      = 4'hF;
   localparam logic [3:0] ST_RTI      = 4'hC;
   localparam logic [3:0] ST_SEL_DR   = 4'h7;
   localparam logic [3:0] ST_CAP_DR   = 4'h6;
   localparam logic [3:0] ST_SH_DR    = 4'h2;
   localparam logic [3:0] ST_EX1_DR   = 4'h1;
   localparam logic [3:0] ST_PAUSE_DR = 4'h3;
   localparam logic [3:0] ST_EX2_DR   = 4'h0;
   localparam logic [3:0] ST_UPD_DR   = 4'h5;
   localparam logic [3:0] ST_SEL_IR   = 4'h4;
   localparam logic [3:0] ST_CAP_IR   = 4'hE;
   localparam logic [3:0] ST_SH_IR    = 4'hA;
   localparam logic [3:0] ST_EX1_IR   = 4'h9;
   localparam logic [3:0] ST_PAUSE_IR = 4'hB;
   localparam logic [3:0] ST_EX2_IR   = 4'h8;
   localparam logic [3:0] ST_UPD_IR   = 4'hD;

   typedef enum logic [3:0] {
      TAP_TLR      = ST_TLR,
      TAP_RTI      = ST_RTI,
      TAP_SEL_DR   = ST_SEL_DR,
      TAP_CAP_DR   = ST_CAP_DR,
      TAP_SH_DR    = ST_SH_DR,
      TAP_EX1_DR   = ST_EX1_DR,
      TAP_PAUSE_DR = ST_PAUSE_DR,
      TAP_EX2_DR   = ST_EX2_DR,
      TAP_UPD_DR   = ST_UPD_DR,
      TAP_SEL_IR   = ST_SEL_IR,
      TAP_CAP_IR   = ST_CAP_IR,
      TAP_SH_IR    = ST_SH_IR,
      TAP_EX1_IR   = ST_EX1_IR,
      TAP_PAUSE_IR = ST_PAUSE_IR,
      TAP_EX2_IR   = ST_EX2_IR,
      TAP_UPD_IR   = ST_UPD_IR
   } tap_state_e;

   // Opcodes are zero-extended to the IR width at the point of use; BYPASS is all ones.
   localparam logic [31:0] OP_EXTEST = 32'd0;
   localparam logic [31:0] OP_SAMPLE = 32'd1;
   localparam logic [31:0] OP_IDCODE = 32'd2;
   localparam logic [31:0] OP_INTEST = 32'd3;

   typedef enum logic [1:0] {
      DR_BYPASS = 2'd0,
      DR_IDCODE = 2'd1,
      DR_BSR    = 2'd2
   } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine with Capture/Shift/Update strobes decoded from the state register.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       tck,
   input  logic       trst,
   input  logic       tms,
   output tap_state_e state,
   output logic       tlr,
   output logic       capture_dr,
   output logic       shift_dr,
   output logic       update_dr,
   output logic       capture_ir,
   output logic       shift_ir,
   output logic       update_ir
);

   tap_state_e state_r;

   // TAP state register and next-state transitions on TMS
   always_ff @(posedge tck) begin
      if (trst) begin
         state_r <= TAP_TLR;
      end else begin
         case (state_r)
            TAP_TLR:      state_r <= tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      state_r <= tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   state_r <= tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   state_r <= tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:    state_r <= tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR:   state_r <= tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_r <= tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_r <= tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR:   state_r <= tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   state_r <= tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   state_r <= tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:    state_r <= tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR:   state_r <= tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_r <= tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_r <= tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR:   state_r <= tms ? TAP_SEL_DR : TAP_RTI;
            default:      state_r <= TAP_TLR;
         endcase
      end
   end

   // Actions fire on the edge that leaves a state, so strobes are simply "currently in" flags.
   assign state      = state_r;
   assign tlr        = (state_r == TAP_TLR);
   assign capture_dr = (state_r == TAP_CAP_DR);
   assign shift_dr   = (state_r == TAP_SH_DR);
   assign update_dr  = (state_r == TAP_UPD_DR);
   assign capture_ir = (state_r == TAP_CAP_IR);
   assign shift_ir   = (state_r == TAP_SH_IR);
   assign update_ir  = (state_r == TAP_UPD_IR);

endmodule

// File: rtl/jtag_bscan_ic.sv
// JTAG boundary-scan wrapper: TAP, parametrised IR, BYPASS/IDCODE/BSR data registers and pin muxing.
// Optional INTEST (opcode 3) is enabled by defining JTAG_INTEST_EN.
module jtag_bscan_ic
   import jtag_pkg::*;
#(
   parameter int          IR_W       = 4,
   parameter int          N_IN       = 4,
   parameter int          N_OUT      = 2,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
)(
   input  logic             TCK,
   input  logic             TRST,
   input  logic             TMS,
   input  logic             TDI,
   output logic             TDO,
   output logic             TDO_EN,
   output logic [3:0]       STATE,
   input  logic [N_IN-1:0]  pin_in,
   output logic [N_IN-1:0]  core_in,
   input  logic [N_OUT-1:0] core_out,
   output logic [N_OUT-1:0] pin_out
);

   localparam int L = N_IN + N_OUT;

   localparam logic [IR_W-1:0] OPC_EXTEST = IR_W'(OP_EXTEST);
   localparam logic [IR_W-1:0] OPC_SAMPLE = IR_W'(OP_SAMPLE);
   localparam logic [IR_W-1:0] OPC_IDCODE = IR_W'(OP_IDCODE);
`ifdef JTAG_INTEST_EN
   localparam logic [IR_W-1:0] OPC_INTEST = IR_W'(OP_INTEST);
`endif
   localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-1){1'b0}}, 1'b1};

   tap_state_e      state_s;
   logic            tlr_s;
   logic            capture_dr_s, shift_dr_s, update_dr_s;
   logic            capture_ir_s, shift_ir_s, update_ir_s;

   logic [IR_W-1:0] ir_sh_r;
   logic [IR_W-1:0] ir_r;
   logic [IR_W-1:0] instr_s;
   dr_sel_e         dr_sel_s;
   logic            dr_tdo_s;

   logic            bypass_r;
   logic [31:0]     idcode_r;
   logic [L-1:0]    bsr_r;
   logic [L-1:0]    bsr_upd_r;
   logic            tdo_r;
   logic            tdo_en_r;

   jtag_tap_fsm u_tap_fsm (
      .tck        (TCK),
      .trst       (TRST),
      .tms        (TMS),
      .state      (state_s),
      .tlr        (tlr_s),
      .capture_dr (capture_dr_s),
      .shift_dr   (shift_dr_s),
      .update_dr  (update_dr_s),
      .capture_ir (capture_ir_s),
      .shift_ir   (shift_ir_s),
      .update_ir  (update_ir_s)
   );

   assign STATE  = state_s;
   assign TDO    = tdo_r;
   assign TDO_EN = tdo_en_r;

   // Effective instruction: TLR overrides the latch so IDCODE is visible the moment TLR is reached
   always_comb begin
      instr_s = ir_r;
      if (tlr_s) begin
         instr_s = OPC_IDCODE;
      end else begin
         instr_s = ir_r;
      end
   end

   // Data-register select; unknown opcodes fall through to BYPASS
   always_comb begin
      dr_sel_s = DR_BYPASS;
      if ((instr_s == OPC_EXTEST) || (instr_s == OPC_SAMPLE)) begin
         dr_sel_s = DR_BSR;
`ifdef JTAG_INTEST_EN
      end else if (instr_s == OPC_INTEST) begin
         dr_sel_s = DR_BSR;
`endif
      end else if (instr_s == OPC_IDCODE) begin
         dr_sel_s = DR_IDCODE;
      end else begin
         dr_sel_s = DR_BYPASS;
      end
   end

   // Serial output bit of the selected data register
   always_comb begin
      dr_tdo_s = bypass_r;
      case (dr_sel_s)
         DR_BSR:    dr_tdo_s = bsr_r[0];
         DR_IDCODE: dr_tdo_s = idcode_r[0];
         default:   dr_tdo_s = bypass_r;
      endcase
   end

   // Pin muxing between functional path and boundary-scan update latches
   always_comb begin
      core_in = pin_in;
      pin_out = core_out;
      if (instr_s == OPC_EXTEST) begin
         pin_out = bsr_upd_r[L-1:N_IN];
`ifdef JTAG_INTEST_EN
      end else if (instr_s == OPC_INTEST) begin
         pin_out = bsr_upd_r[L-1:N_IN];
         core_in = bsr_upd_r[N_IN-1:0];
`endif
      end else begin
         pin_out = core_out;
      end
   end

   // Instruction shift stage and instruction latch
   always_ff @(posedge TCK) begin
      if (TRST) begin
         ir_sh_r <= IR_CAPTURE;
         ir_r    <= OPC_IDCODE;
      end else begin
         if (capture_ir_s) begin
            ir_sh_r <= IR_CAPTURE;
         end else if (shift_ir_s) begin
            ir_sh_r <= {TDI, ir_sh_r[IR_W-1:1]};
         end else begin
            ir_sh_r <= ir_sh_r;
         end
         if (tlr_s) begin
            ir_r <= OPC_IDCODE;
         end else if (update_ir_s) begin
            ir_r <= ir_sh_r;
         end else begin
            ir_r <= ir_r;
         end
      end
   end

   // Data registers: capture/shift only the selected one; BSR update latches only when BSR is selected
   always_ff @(posedge TCK) begin
      if (TRST) begin
         bypass_r  <= 1'b0;
         idcode_r  <= IDCODE_VAL;
         bsr_r     <= {L{1'b0}};
         bsr_upd_r <= {L{1'b0}};
      end else begin
         if (capture_dr_s) begin
            case (dr_sel_s)
               DR_BSR:    bsr_r    <= {core_out, pin_in};
               DR_IDCODE: idcode_r <= IDCODE_VAL;
               default:   bypass_r <= 1'b0;
            endcase
         end else if (shift_dr_s) begin
            case (dr_sel_s)
               DR_BSR:    bsr_r    <= {TDI, bsr_r[L-1:1]};
               DR_IDCODE: idcode_r <= {TDI, idcode_r[31:1]};
               default:   bypass_r <= TDI;
            endcase
         end
         if (update_dr_s && (dr_sel_s == DR_BSR)) begin
            bsr_upd_r <= bsr_r;
         end
      end
   end

   // Falling-edge TDO stage; TDO holds its last bit outside shift states
   always_ff @(negedge TCK) begin
      if (TRST) begin
         tdo_r    <= 1'b0;
         tdo_en_r <= 1'b0;
      end else if (shift_ir_s) begin
         tdo_r    <= ir_sh_r[0];
         tdo_en_r <= 1'b1;
      end else if (shift_dr_s) begin
         tdo_r    <= dr_tdo_s;
         tdo_en_r <= 1'b1;
      end else begin
         tdo_r    <= tdo_r;
         tdo_en_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jtag_bscan_ic.sv
// Self-checking bench for jtag_bscan_ic: directed scenarios plus randomized IR/DR traffic vs a stream model.
module tb_jtag_bscan_ic;

   localparam int          IR_W = 4;
   localparam int          N_IN = 4;
   localparam int          N_OUT = 2;
   localparam int          L = N_IN + N_OUT;
   localparam logic [31:0] IDV = 32'h1000_0001;

   logic             TCK = 1'b0;
   logic             TRST = 1'b1;
   logic             TMS = 1'b1;
   logic             TDI = 1'b0;
   logic             TDO, TDO_EN;
   logic [3:0]       STATE;
   logic [N_IN-1:0]  pin_in = 4'h0;
   logic [N_IN-1:0]  core_in;
   logic [N_OUT-1:0] core_out = 2'b00;
   logic [N_OUT-1:0] pin_out;

   int n_cmp = 0;
   int n_bad = 0;
   int en_cnt = 0;

   // Reference model state
   logic [3:0]   model_instr = 4'd2;
   logic [L-1:0] model_upd = '0;

   jtag_bscan_ic #(.IR_W(IR_W), .N_IN(N_IN), .N_OUT(N_OUT), .IDCODE_VAL(IDV)) dut (
      .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN), .STATE(STATE),
      .pin_in(pin_in), .core_in(core_in), .core_out(core_out), .pin_out(pin_out)
   );

   always #5 TCK = ~TCK;

   function automatic logic [127:0] msk(input int m);
      return (128'd1 << m) - 128'd1;
   endfunction

   // DR length and capture value as implied by the opcode rules
   function automatic int dr_len(input logic [3:0] op);
      if (op == 4'd0 || op == 4'd1) return L;
      if (op == 4'd2) return 32;
      return 1;
   endfunction

   function automatic logic [63:0] dr_cap(input logic [3:0] op);
      if (op == 4'd0 || op == 4'd1) return 64'({core_out, pin_in});
      if (op == 4'd2) return 64'(IDV);
      return 64'd0;
   endfunction

   task automatic tick(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #1;
      if (TDO_EN === 1'b1) en_cnt++;
   endtask

   // From Run-Test/Idle: load an opcode, collect the captured IR bits, end in Run-Test/Idle
   task automatic shift_ir(input logic [3:0] op, output logic [3:0] cap_out);
      en_cnt = 0;
      tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      cap_out[0] = TDO;
      for (int i = 0; i < IR_W; i++) begin
         tick(i == IR_W - 1, op[i]);
         if (i < IR_W - 1) cap_out[i+1] = TDO;
      end
      tick(1'b1, 1'b0); tick(1'b0, 1'b0);
      model_instr = op;
   endtask

   // From Run-Test/Idle: shift n bits through the selected DR; exp is the model's TDO stream
   task automatic shift_dr(input int n, input logic [63:0] din_raw, input bit do_upd,
                           output logic [63:0] dout, output logic [63:0] exp);
      logic [127:0] s;
      logic [63:0]  din;
      int           m;
      din = din_raw & msk(n)[63:0];
      m = dr_len(model_instr);
      s = (128'(din) << m) | (128'(dr_cap(model_instr)) & msk(m));
      exp = 64'(s & msk(n));
      dout = '0;
      en_cnt = 0;
      tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      dout[0] = TDO;
      for (int i = 0; i < n; i++) begin
         tick(i == n - 1, din[i]);
         if (i < n - 1) dout[i+1] = TDO;
      end
      if (do_upd) begin
         tick(1'b1, 1'b0); tick(1'b0, 1'b0);
         if (model_instr == 4'd0 || model_instr == 4'd1) model_upd = L'((s >> n) & msk(m));
      end
   endtask

   task automatic test_reset;
      pin_in = 4'($urandom);
      core_out = 2'($urandom);
      TRST = 1'b1;
      tick(1'b1, 1'b0); tick(1'b0, 1'b1);
      model_instr = 4'd2; model_upd = '0;
      n_cmp++; if (STATE !== 4'hF) begin n_bad++; $display("FAIL reset_state: got %h want %h", STATE, 4'hF); end
      n_cmp++; if (TDO !== 1'b0) begin n_bad++; $display("FAIL reset_tdo: got %b want 0", TDO); end
      n_cmp++; if (TDO_EN !== 1'b0) begin n_bad++; $display("FAIL reset_tdo_en: got %b want 0", TDO_EN); end
      n_cmp++; if (pin_out !== core_out) begin n_bad++; $display("FAIL reset_pin_out: got %b want %b", pin_out, core_out); end
      n_cmp++; if (core_in !== pin_in) begin n_bad++; $display("FAIL reset_core_in: got %b want %b", core_in, pin_in); end
      TRST = 1'b0;
      tick(1'b0, 1'b0);
      n_cmp++; if (STATE !== 4'hC) begin n_bad++; $display("FAIL reset_to_rti: got %h want %h", STATE, 4'hC); end
   endtask

   task automatic test_idcode;
      logic [63:0] d, e;
      shift_dr(32, {$urandom, $urandom}, 1'b1, d, e);
      n_cmp++; if (d[31:0] !== IDV) begin n_bad++; $display("FAIL idcode_stream: got %h want %h", d[31:0], IDV); end
      n_cmp++; if (en_cnt !== 32) begin n_bad++; $display("FAIL idcode_tdo_en: got %0d want 32", en_cnt); end
      n_cmp++; if (STATE !== 4'hC) begin n_bad++; $display("FAIL idcode_end_state: got %h want C", STATE); end
   endtask

   task automatic test_ir_capture;
      logic [3:0] c;
      shift_ir(4'hF, c);
      n_cmp++; if (c !== 4'b0001) begin n_bad++; $display("FAIL ir_capture: got %b want 0001", c); end
      n_cmp++; if (en_cnt !== IR_W) begin n_bad++; $display("FAIL ir_tdo_en: got %0d want %0d", en_cnt, IR_W); end
   endtask

   task automatic test_bypass;
      logic [63:0] d, e;
      shift_dr(8, 64'b1011_0011, 1'b1, d, e);
      n_cmp++; if (d[7:0] !== 8'b0110_0110) begin n_bad++; $display("FAIL bypass_stream: got %b want 01100110", d[7:0]); end
      n_cmp++; if (en_cnt !== 8) begin n_bad++; $display("FAIL bypass_tdo_en: got %0d want 8", en_cnt); end
   endtask

   task automatic test_sample;
      logic [3:0]  c;
      logic [63:0] d, e;
      pin_in = 4'b1010;
      core_out = 2'b01;
      shift_ir(4'd1, c);
      shift_dr(6, 64'($urandom), 1'b1, d, e);
      n_cmp++; if (d[5:0] !== 6'b011010) begin n_bad++; $display("FAIL sample_stream: got %b want 011010", d[5:0]); end
      n_cmp++; if (pin_out !== core_out) begin n_bad++; $display("FAIL sample_pin_out: got %b want %b", pin_out, core_out); end
   endtask

   task automatic test_extest;
      logic [3:0]  c;
      logic [63:0] d, e;
      shift_ir(4'd0, c);
      n_cmp++; if (pin_out !== model_upd[L-1:N_IN]) begin n_bad++; $display("FAIL extest_entry_pin_out: got %b want %b", pin_out, model_upd[L-1:N_IN]); end
      shift_dr(6, 64'b10_0000, 1'b1, d, e);
      n_cmp++; if (pin_out !== 2'b10) begin n_bad++; $display("FAIL extest_pin_out: got %b want 10", pin_out); end
      core_out = ~core_out;
      #1;
      n_cmp++; if (pin_out !== 2'b10) begin n_bad++; $display("FAIL extest_isolated: got %b want 10", pin_out); end
      shift_ir(4'hF, c);
      n_cmp++; if (pin_out !== core_out) begin n_bad++; $display("FAIL extest_restore: got %b want %b", pin_out, core_out); end
   endtask

   task automatic test_tlr_via_tms;
      logic [63:0] d, e;
      tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
      n_cmp++; if (STATE !== 4'hB) begin n_bad++; $display("FAIL pause_ir_state: got %h want B", STATE); end
      repeat (5) tick(1'b1, 1'b0);
      n_cmp++; if (STATE !== 4'hF) begin n_bad++; $display("FAIL tms_tlr_state: got %h want F", STATE); end
      model_instr = 4'd2;
      tick(1'b0, 1'b0);
      shift_dr(32, {$urandom, $urandom}, 1'b1, d, e);
      n_cmp++; if (d[31:0] !== IDV) begin n_bad++; $display("FAIL tms_tlr_idcode: got %h want %h", d[31:0], IDV); end
   endtask

   task automatic test_trst_mid_shift;
      logic [3:0] c;
      TRST = 1'b1; tick(1'b1, 1'b0); TRST = 1'b0;
      model_instr = 4'd2; model_upd = '0;
      tick(1'b0, 1'b0);
      shift_ir(4'd0, c);
      n_cmp++; if (pin_out !== 2'b00) begin n_bad++; $display("FAIL trst_pre_pin_out: got %b want 00", pin_out); end
      tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1);
      TRST = 1'b1;
      tick(1'b0, 1'b1);
      n_cmp++; if (STATE !== 4'hF) begin n_bad++; $display("FAIL trst_mid_state: got %h want F", STATE); end
      n_cmp++; if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin n_bad++; $display("FAIL trst_mid_tdo: got %b/%b want 0/0", TDO, TDO_EN); end
      TRST = 1'b0;
      model_instr = 4'd2; model_upd = '0;
      tick(1'b0, 1'b0);
      shift_ir(4'd0, c);
      n_cmp++; if (pin_out !== 2'b00) begin n_bad++; $display("FAIL trst_upd_untouched: got %b want 00", pin_out); end
   endtask

   task automatic test_random;
      logic [3:0]  op, c;
      logic [63:0] d, e;
      logic [N_OUT-1:0] exp_pin;
      int n;
      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 5))
            0:       op = 4'd0;
            1:       op = 4'd1;
            2:       op = 4'd2;
            3:       op = 4'd3;
            4:       op = 4'hF;
            default: op = 4'($urandom_range(4, 14));
         endcase
         pin_in = 4'($urandom);
         core_out = 2'($urandom);
         shift_ir(op, c);
         n_cmp++; if (c !== 4'b0001) begin n_bad++; $display("FAIL rand_ir_capture[%0d]: got %b want 0001", it, c); end
         n = $urandom_range(1, 40);
         shift_dr(n, {$urandom, $urandom}, 1'b1, d, e);
         n_cmp++; if (d !== e) begin n_bad++; $display("FAIL rand_dr_stream[%0d] op=%0d n=%0d: got %h want %h", it, op, n, d, e); end
         exp_pin = (model_instr == 4'd0) ? model_upd[L-1:N_IN] : core_out;
         n_cmp++; if (pin_out !== exp_pin) begin n_bad++; $display("FAIL rand_pin_out[%0d]: got %b want %b", it, pin_out, exp_pin); end
         n_cmp++; if (core_in !== pin_in) begin n_bad++; $display("FAIL rand_core_in[%0d]: got %b want %b", it, core_in, pin_in); end
         n_cmp++; if (STATE !== 4'hC) begin n_bad++; $display("FAIL rand_state[%0d]: got %h want C", it, STATE); end
      end
   endtask

   initial begin
      test_reset;
      test_idcode;
      test_ir_capture;
      test_bypass;
      test_sample;
      test_extest;
      test_tlr_via_tms;
      test_trst_mid_shift;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
